// File: rtl/seq_divider_16_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_divider_16_if : start/done handshake and operand/result bundle for the  |
// |                     sequential divider.  Rev 1.0                            |
// +----------------------------------------------------------------------------+
interface seq_divider_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider_16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_divider_16 : multi-cycle unsigned restoring divider, one quotient bit   |
// |                  per clock, start/done handshake.  Rev 1.0                  |
// +----------------------------------------------------------------------------+
module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_16_if.slave   bus
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;
  logic               w_last;

  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  // Partial remainder always stays below the divisor, so WIDTH bits suffice between iterations.
  logic [WIDTH-1:0]   r_r;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  logic [WIDTH:0]     w_r_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_r_next;
  logic [WIDTH-1:0]   w_q_next;

  assign w_r_shift = {r_r, r_q[WIDTH-1]};
  assign w_trial   = w_r_shift - {1'b0, r_d};
  assign w_r_next  = w_trial[WIDTH] ? w_r_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_next  = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_last    = (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        w_done = (r_state == S_FIN);
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = (bus.divisor == '0) ? S_FIN : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_FIN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_q   <= bus.dividend;
      r_d   <= bus.divisor;
      r_r   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
      // Divide-by-zero resolves immediately; otherwise old results hold until the run ends.
      if (bus.divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend;
        r_dbz       <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + c_CNT_W'(1);
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_r_next;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_divider_16 : directed and randomised checks of seq_divider_16.       |
// |                     Rev 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_seq_divider_16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider_16_if #(.WIDTH(16)) bus ();

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Starts from a negedge with start already driven; returns at the negedge of the done cycle.
  task automatic wait_done(input bit chain, input logic [15:0] na, input logic [15:0] nb,
                           output logic [15:0] q, output logic [15:0] r, output logic dbz,
                           output int lat, output int busyc, output bit overlap);
    lat = 0; busyc = 0; overlap = 1'b0; q = '0; r = '0; dbz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.busy) busyc++;
      if (bus.done) begin
        q   = bus.quotient;
        r   = bus.remainder;
        dbz = bus.div_by_zero;
        if (chain) begin
          bus.start    = 1'b1;
          bus.dividend = na;
          bus.divisor  = nb;
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== 16'h0 ||
          bus.remainder !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: busy/done/dbz=%b%b%b q=%h r=%h, need 000 q=0000 r=0000",
                 i, bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] q, r; logic dbz; int lat, busyc; bit ov;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    wait_done(1'b0, 16'h0, 16'h0, q, r, dbz, lat, busyc, ov);
    n_checks++;
    if (lat !== 17 || busyc !== 16 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_timing: lat=%0d busy_cycles=%0d overlap=%b, need 17/16/0", lat, busyc, ov);
    end
    n_checks++;
    if (q !== 16'd14 || r !== 16'd2 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b, need 14/2/0", q, r, dbz);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
      n_fail++;
      $display("FAIL basic_hold: done=%b busy=%b q=%0d r=%0d, need 0/0/14/2",
               bus.done, bus.busy, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q, r; logic dbz; int lat, busyc; bit ov;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'hFFFF; bus.divisor = 16'd1;
    wait_done(1'b1, 16'd5, 16'd9, q, r, dbz, lat, busyc, ov);
    n_checks++;
    if (lat !== 17 || q !== 16'hFFFF || r !== 16'h0 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d q=%h r=%h dbz=%b, need 17/ffff/0000/0", lat, q, r, dbz);
    end
    wait_done(1'b0, 16'h0, 16'h0, q, r, dbz, lat, busyc, ov);
    n_checks++;
    if (lat !== 17 || busyc !== 16 || q !== 16'd0 || r !== 16'd5 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d busy=%0d q=%0d r=%0d dbz=%b, need 17/16/0/5/0",
               lat, busyc, q, r, dbz);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q, r; logic dbz; int lat, busyc; bit ov;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'h1234; bus.divisor = 16'h0;
    wait_done(1'b0, 16'h0, 16'h0, q, r, dbz, lat, busyc, ov);
    n_checks++;
    if (lat !== 1 || busyc !== 0 || q !== 16'hFFFF || r !== 16'h1234 || dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero: lat=%0d busy=%0d q=%h r=%h dbz=%b, need 1/0/ffff/1234/1",
               lat, busyc, q, r, dbz);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1 || bus.quotient !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL div_zero_hold: done=%b dbz=%b q=%h, need 0/1/ffff",
               bus.done, bus.div_by_zero, bus.quotient);
    end
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 16'hFFFF ||
        bus.remainder !== 16'h1234) begin
      n_fail++;
      $display("FAIL dbz_clear: dbz=%b busy=%b q=%h r=%h, need 0/1/ffff/1234",
               bus.div_by_zero, bus.busy, bus.quotient, bus.remainder);
    end
    wait_done(1'b0, 16'h0, 16'h0, q, r, dbz, lat, busyc, ov);
    n_checks++;
    if (lat !== 16 || q !== 16'd14 || r !== 16'd2 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL after_dbz: lat=%0d q=%0d r=%0d dbz=%b, need 16/14/2/0", lat, q, r, dbz);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd10;
    @(posedge clk);
    bad = 0;
    for (int it = 1; it <= 10; it++) begin
      @(negedge clk);
      bus.start = (it == 5);
      if (it == 5) begin
        bus.dividend = 16'd50; bus.divisor = 16'd5;
      end
      if (it == 10) rst_n = 1'b0;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      @(posedge clk);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mid_busy: %0d cycles not busy or done before reset, need 0", bad);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== 16'h0 ||
        bus.remainder !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: busy/done/dbz=%b%b%b q=%h r=%h, need 000 q=0000 r=0000",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: %0d cycles with busy or done, need 0", bad);
    end
  endtask

  task automatic test_random();
    logic [15:0] da [9];
    logic [15:0] db [9];
    logic [15:0] a, b, q, r;
    logic [31:0] recon;
    logic dbz; int lat, busyc; bit ov, ok; int mode;
    da = '{16'd5, 16'd9, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd0, 16'd1, 16'hFFFF, 16'hABCD};
    db = '{16'd9, 16'd9, 16'h8000, 16'h8000, 16'h8000, 16'd3, 16'hFFFF, 16'hFFFF, 16'h0000};
    for (int n = 0; n < 1000; n++) begin
      if (n < 9) begin
        a = da[n]; b = db[n];
      end else begin
        mode = int'($urandom_range(0, 9));
        a = 16'($urandom_range(0, 16'hFFFF));
        b = 16'($urandom_range(0, 16'hFFFF));
        if (mode == 0) b = a;
        else if (mode == 1) b = 16'h8000;
        else if (mode == 2) begin
          a = 16'($urandom_range(0, 16'h7FFE));
          b = 16'($urandom_range(int'(a) + 1, 16'hFFFF));
        end else if (mode == 3) b = 16'h0;
      end
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      wait_done(1'b0, 16'h0, 16'h0, q, r, dbz, lat, busyc, ov);
      recon = 32'(q) * 32'(b) + 32'(r);
      if (b == 16'h0)
        ok = (q === 16'hFFFF) && (r === a) && (dbz === 1'b1) && (lat == 1) && (busyc == 0);
      else
        ok = (recon == 32'(a)) && (r < b) && (q === a / b) && (r === a % b) && (dbz === 1'b0) &&
             (lat == 17) && (busyc == 16) && !ov;
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL random #%0d %h/%h: q=%h r=%h dbz=%b lat=%0d busy=%0d ov=%b, need q=%h r=%h",
                 n, a, b, q, r, dbz, lat, busyc, ov,
                 (b == 16'h0) ? 16'hFFFF : a / b, (b == 16'h0) ? a : a % b);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
